mz_pulse_decoder: RTL and testbench

Receive-side monitor for the Mach-Zehnder RF gate sequence (pi/2 – gap – pi – gap – pi/2) produced by the pulse sequencer.
- Samples the rf gate line and measures the width of all five segments in clock cycles.
- Checks each width against the expected timing within a tolerance.
- Reports the measured widths plus a pass/fail code per sequence.
- Sits beside the sequencer in simulation and on the board as a self-check of the emitted gate.

---
 rtl/mz_pulse_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_mz_pulse_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mz_pulse_decoder.sv
// Receive-side monitor for the MZ gate (pi/2 - gap - pi - gap - pi/2): measures five segment widths and grades them.
// Optional `MZ_DECODE_SYNC_EN adds a 2-flop synchroniser ahead of the rf_s register for an asynchronous gate source.
module mz_pulse_decoder #(
    parameter int unsigned PI2_LEN = 10,
    parameter int unsigned PI_LEN  = 20,
    parameter int unsigned GAP_LEN = 20,
    parameter int unsigned TOL     = 1,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rf_in,
    input  logic             arm,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             seq_ok,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] pi2a_len,
    output logic [CNT_W-1:0] gap1_len,
    output logic [CNT_W-1:0] pi_len,
    output logic [CNT_W-1:0] gap2_len,
    output logic [CNT_W-1:0] pi2b_len
);

    typedef enum logic [2:0] {IDLE, WAIT_P1, P1, G1, P2, G2, P3} state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LEN = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             rf_raw, rf_s_q, rf_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             busy_q, busy_d, done_q, done_d, seq_ok_q, seq_ok_d;
    logic [2:0]       err_q, err_d, err_p3;
    logic [CNT_W-1:0] pi2a_q, pi2a_d, gap1_q, gap1_d, pi_q, pi_d;
    logic [CNT_W-1:0] gap2_q, gap2_d, pi2b_q, pi2b_d;
    logic             rise, fall, gap_tmo, tmo;

`ifdef MZ_DECODE_SYNC_EN
    logic [1:0] sync_q;
    assign rf_raw = sync_q[1];
`else
    assign rf_raw = rf_in;
`endif

    function automatic logic out_of_tol(input logic [CNT_W-1:0] len, input int unsigned exp_len);
        int unsigned l;
        l = 32'(len);
        return (l > exp_len + TOL) || (l + TOL < exp_len);
    endfunction

    // Only the first failing segment is reported.
    function automatic logic [2:0] first_err(input logic [2:0] cur, input logic bad, input logic [2:0] code);
        return (cur == 3'd0 && bad) ? code : cur;
    endfunction

    assign rise    = rf_s_q & ~rf_prev_q;
    assign fall    = ~rf_s_q & rf_prev_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
    // The cycle that would bring the count to TIMEOUT ends the wait.
    assign gap_tmo = (rf_s_q == rf_prev_q) && (cnt_q >= TMO_LEN - ONE);
    assign err_p3  = first_err(err_q, out_of_tol(cnt_q, PI2_LEN), 3'd5);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        seq_ok_d = seq_ok_q;
        err_d    = err_q;
        pi2a_d   = pi2a_q;
        gap1_d   = gap1_q;
        pi_d     = pi_q;
        gap2_d   = gap2_q;
        pi2b_d   = pi2b_q;
        tmo      = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (arm) begin
                    state_d  = WAIT_P1;
                    cnt_d    = ONE;
                    err_d    = 3'd0;
                    seq_ok_d = 1'b0;
                    pi2a_d   = '0;
                    gap1_d   = '0;
                    pi_d     = '0;
                    gap2_d   = '0;
                    pi2b_d   = '0;
                end
                WAIT_P1: begin
                    if (rise) begin
                        state_d = P1;
                        cnt_d   = ONE;
                    end else if (gap_tmo) tmo = 1'b1;
                    else if (fall)        cnt_d = ONE;
                    else                  cnt_d = cnt_inc;
                end
                P1: begin
                    if (fall) begin
                        pi2a_d  = cnt_q;
                        err_d   = first_err(err_q, out_of_tol(cnt_q, PI2_LEN), 3'd1);
                        state_d = G1;
                        cnt_d   = ONE;
                    end else cnt_d = cnt_inc;
                end
                G1: begin
                    if (rise) begin
                        gap1_d  = cnt_q;
                        err_d   = first_err(err_q, out_of_tol(cnt_q, GAP_LEN), 3'd2);
                        state_d = P2;
                        cnt_d   = ONE;
                    end else if (gap_tmo) begin
                        gap1_d = TMO_LEN;
                        tmo    = 1'b1;
                    end else cnt_d = cnt_inc;
                end
                P2: begin
                    if (fall) begin
                        pi_d    = cnt_q;
                        err_d   = first_err(err_q, out_of_tol(cnt_q, PI_LEN), 3'd3);
                        state_d = G2;
                        cnt_d   = ONE;
                    end else cnt_d = cnt_inc;
                end
                G2: begin
                    if (rise) begin
                        gap2_d  = cnt_q;
                        err_d   = first_err(err_q, out_of_tol(cnt_q, GAP_LEN), 3'd4);
                        state_d = P3;
                        cnt_d   = ONE;
                    end else if (gap_tmo) begin
                        gap2_d = TMO_LEN;
                        tmo    = 1'b1;
                    end else cnt_d = cnt_inc;
                end
                P3: begin
                    if (fall) begin
                        pi2b_d   = cnt_q;
                        err_d    = err_p3;
                        seq_ok_d = (err_p3 == 3'd0);
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else cnt_d = cnt_inc;
                end
                default: state_d = IDLE;
            endcase
            if (tmo) begin
                err_d    = 3'd6;
                seq_ok_d = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // rf_s/rf_prev reset high so a line already high at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MZ_DECODE_SYNC_EN
            sync_q    <= 2'b11;
`endif
            rf_s_q    <= 1'b1;
            rf_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seq_ok_q  <= 1'b0;
            err_q     <= 3'd0;
            pi2a_q    <= '0;
            gap1_q    <= '0;
            pi_q      <= '0;
            gap2_q    <= '0;
            pi2b_q    <= '0;
        end else begin
`ifdef MZ_DECODE_SYNC_EN
            sync_q    <= {sync_q[0], rf_in};
`endif
            rf_s_q    <= rf_raw;
            rf_prev_q <= rf_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            seq_ok_q  <= seq_ok_d;
            err_q     <= err_d;
            pi2a_q    <= pi2a_d;
            gap1_q    <= gap1_d;
            pi_q      <= pi_d;
            gap2_q    <= gap2_d;
            pi2b_q    <= pi2b_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign seq_ok   = seq_ok_q;
    assign err_code = err_q;
    assign pi2a_len = pi2a_q;
    assign gap1_len = gap1_q;
    assign pi_len   = pi_q;
    assign gap2_len = gap2_q;
    assign pi2b_len = pi2b_q;

endmodule

// File: tb/tb_mz_pulse_decoder.sv
// Randomised bench for mz_pulse_decoder: drives gate waveforms and grades them against a run-length model.
module tb_mz_pulse_decoder;

    localparam int PI2_LEN = 10;
    localparam int PI_LEN  = 20;
    localparam int GAP_LEN = 20;
    localparam int TOL     = 1;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 16;
`ifdef MZ_DECODE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rf_in = 1'b0;
    logic arm = 1'b0;
    logic abort = 1'b0;
    logic busy, done, seq_ok;
    logic [2:0] err_code;
    logic [CNT_W-1:0] pi2a_len, gap1_len, pi_len, gap2_len, pi2b_len;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    mz_pulse_decoder #(
        .PI2_LEN(PI2_LEN), .PI_LEN(PI_LEN), .GAP_LEN(GAP_LEN),
        .TOL(TOL), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .arm(arm), .abort(abort),
        .busy(busy), .done(done), .seq_ok(seq_ok), .err_code(err_code),
        .pi2a_len(pi2a_len), .gap1_len(gap1_len), .pi_len(pi_len),
        .gap2_len(gap2_len), .pi2b_len(pi2b_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int n);
        rf_in = lvl;
        repeat (n) tick();
    endtask

    // Expected outcome from the five run lengths seen after arm.
    task automatic model(input int w[5], output int len[5], output int err, output int ok, output bit tmo);
        int nominal[5];
        nominal[0] = PI2_LEN; nominal[1] = GAP_LEN; nominal[2] = PI_LEN;
        nominal[3] = GAP_LEN; nominal[4] = PI2_LEN;
        err = 0;
        tmo = 1'b0;
        for (int k = 0; k < 5; k++) len[k] = 0;
        for (int k = 0; k < 5; k++) begin
            if (!tmo) begin
                if ((k == 1 || k == 3) && w[k] >= TIMEOUT) begin
                    len[k] = TIMEOUT;
                    err = 6;
                    tmo = 1'b1;
                end else begin
                    len[k] = w[k];
                    if (err == 0 && (w[k] - nominal[k] > TOL || nominal[k] - w[k] > TOL))
                        err = k + 1;
                end
            end
        end
        ok = (!tmo && err == 0) ? 1 : 0;
    endtask

    task automatic check_lens(input string name, input int e_len[5]);
        check_eq({name, ".pi2a"}, longint'(pi2a_len), e_len[0]);
        check_eq({name, ".gap1"}, longint'(gap1_len), e_len[1]);
        check_eq({name, ".pi"},   longint'(pi_len),   e_len[2]);
        check_eq({name, ".gap2"}, longint'(gap2_len), e_len[3]);
        check_eq({name, ".pi2b"}, longint'(pi2b_len), e_len[4]);
    endtask

    task automatic run_seq(input string name, input bit pre_high, input int w[5]);
        int base, fall_at, e_err, e_ok;
        int e_len[5];
        bit e_tmo;
        rf_in = pre_high;
        repeat (4) tick();
        base = done_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        if (pre_high) drive(1'b1, 5);
        drive(1'b0, 3);
        for (int k = 0; k < 5; k++) drive(k % 2 == 0, w[k]);
        rf_in = 1'b0;
        fall_at = cyc;
        repeat (12) tick();
        model(w, e_len, e_err, e_ok, e_tmo);
        check_eq({name, ".done_count"}, done_cnt - base, 1);
        check_eq({name, ".err_code"}, longint'(err_code), e_err);
        check_eq({name, ".seq_ok"}, longint'(seq_ok), e_ok);
        check_lens(name, e_len);
        check_eq({name, ".busy"}, longint'(busy), 0);
        if (!e_tmo) check_eq({name, ".done_latency"}, done_cyc - fall_at, LAT);
        $display("seq %s pre=%0d w=%0d/%0d/%0d/%0d/%0d -> err=%0d ok=%0d lens=%0d/%0d/%0d/%0d/%0d",
                 name, pre_high, w[0], w[1], w[2], w[3], w[4], err_code, seq_ok,
                 pi2a_len, gap1_len, pi_len, gap2_len, pi2b_len);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, ".busy"}, longint'(busy), 0);
        check_eq({name, ".done"}, longint'(done), 0);
        check_eq({name, ".seq_ok"}, longint'(seq_ok), 0);
        check_eq({name, ".err_code"}, longint'(err_code), 0);
        check_eq({name, ".len_or"}, longint'(pi2a_len | gap1_len | pi_len | gap2_len | pi2b_len), 0);
    endtask

    initial begin
        int w[5];
        int base;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        w = '{10, 20, 20, 20, 10};  run_seq("nominal", 1'b0, w);
        w = '{10, 20, 23, 20, 10};  run_seq("pi_wide", 1'b0, w);
        w = '{10, 20, 20, 300, 10}; run_seq("gap2_timeout", 1'b0, w);
        w = '{10, 20, 20, 20, 10};  run_seq("pre_high", 1'b1, w);
        w = '{9, 20, 20, 20, 10};   run_seq("tol_9", 1'b0, w);
        w = '{11, 20, 20, 20, 10};  run_seq("tol_11", 1'b0, w);
        w = '{8, 20, 20, 20, 10};   run_seq("tol_8", 1'b0, w);
        w = '{8, 20, 23, 20, 10};   run_seq("first_err", 1'b0, w);
        w = '{10, 255, 20, 20, 10}; run_seq("gap1_timeout", 1'b0, w);
        w = '{10, 254, 20, 20, 10}; run_seq("gap1_254", 1'b0, w);

        // Abort during P2: busy drops next cycle, no done, lengths already latched hold.
        base = done_cnt;
        arm = 1'b1; tick(); arm = 1'b0;
        drive(1'b0, 3); drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort.busy", longint'(busy), 0);
        check_eq("abort.pi2a_hold", longint'(pi2a_len), 10);
        check_eq("abort.gap1_hold", longint'(gap1_len), 20);
        drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10); drive(1'b0, 12);
        check_eq("abort.no_done", done_cnt - base, 0);
        check_eq("abort.idle", longint'(busy), 0);
        $display("abort during P2 -> busy=%0d dones=%0d", busy, done_cnt - base);

        // abort beats arm in the same cycle.
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check_eq("abort_arm.busy", longint'(busy), 0);
        $display("abort+arm -> busy=%0d", busy);

        // Async reset mid-G1 clears everything without a clock edge.
        arm = 1'b1; tick(); arm = 1'b0;
        drive(1'b0, 3); drive(1'b1, 10); drive(1'b0, 5);
        check_eq("pre_reset.busy", longint'(busy), 1);
        check_eq("pre_reset.pi2a", longint'(pi2a_len), 10);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        $display("reset mid-G1 -> busy=%0d pi2a=%0d", busy, pi2a_len);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        w = '{10, 20, 20, 20, 10};  run_seq("after_reset", 1'b0, w);

        for (int i = 0; i < 20; i++) begin
            w[0] = PI2_LEN - 2 + int'($urandom_range(0, 4));
            w[1] = GAP_LEN - 2 + int'($urandom_range(0, 4));
            w[2] = PI_LEN - 2 + int'($urandom_range(0, 4));
            w[3] = GAP_LEN - 2 + int'($urandom_range(0, 4));
            w[4] = PI2_LEN - 2 + int'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) w[1] = int'($urandom_range(250, 300));
            if ($urandom_range(0, 7) == 0) w[3] = int'($urandom_range(250, 300));
            run_seq($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
